// File: rtl/step_pattern_sequencer_if.sv
// step_pattern_sequencer_if: edit, transport and display signals of the step sequencer (loop_len present only with SEQ_LOOP_LEN_EN)
interface step_pattern_sequencer_if #(
   parameter int TEMPO_W = 24
);
   logic               press_valid;
   logic [3:0]         press_index;
   logic               clear;
   logic               run;
   logic [TEMPO_W-1:0] period;
   logic [15:0]        pattern;
   logic [3:0]         step;
   logic               step_tick;
   logic               trig;
`ifdef SEQ_LOOP_LEN_EN
   logic [3:0]         loop_len;
   modport master (output press_valid, press_index, clear, run, period, loop_len,
                   input pattern, step, step_tick, trig);
   modport slave (input press_valid, press_index, clear, run, period, loop_len,
                  output pattern, step, step_tick, trig);
`else
   modport master (output press_valid, press_index, clear, run, period,
                   input pattern, step, step_tick, trig);
   modport slave (input press_valid, press_index, clear, run, period,
                  output pattern, step, step_tick, trig);
`endif
endinterface

// File: rtl/step_pattern_sequencer.sv
// step_pattern_sequencer: 16-step toggle pattern with tempo-driven playhead and fixed-width trigger; SEQ_LOOP_LEN_EN adds a loop_len wrap point
module step_pattern_sequencer #(
   parameter int TEMPO_W  = 24,
   parameter int TRIG_LEN = 4
) (
   input logic clk,
   input logic rst,
   step_pattern_sequencer_if.slave bus
);
   typedef enum logic {STOPPED, RUNNING} state_t;
   state_t             state, state_nx;
   logic [TEMPO_W-1:0] tick_cnt, tick_nx, last;
   logic [3:0]         trig_cnt, trig_nx, step, step_nx, wrap;
   logic [15:0]        pattern;
   logic               step_tick, trig, enter;
   assign last = (bus.period < TEMPO_W'(2)) ? TEMPO_W'(1) : bus.period - TEMPO_W'(1);
`ifdef SEQ_LOOP_LEN_EN
   assign wrap = (step >= bus.loop_len) ? 4'd0 : step + 4'd1;
`else
   assign wrap = step + 4'd1;
`endif
   // transport decisions: start, stop, advance, and the trigger countdown for the entered step
   always_comb begin
      state_nx = state;
      enter    = 1'b0;
      step_nx  = step;
      tick_nx  = '0;
      if (state == STOPPED) begin
         state_nx = bus.run ? RUNNING : STOPPED;
         enter    = bus.run;
      end else if (!bus.run) begin
         state_nx = STOPPED;
      end else if (tick_cnt >= last) begin
         enter   = 1'b1;
         step_nx = wrap;
      end else begin
         tick_nx = tick_cnt + TEMPO_W'(1);
      end
      trig_nx = (enter && pattern[step_nx]) ? 4'(TRIG_LEN) : trig_cnt - {3'b0, trig_cnt != 4'd0};
   end
   // playhead, tick counter and trigger registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= STOPPED;
         tick_cnt  <= '0;
         step      <= 4'd0;
         step_tick <= 1'b0;
         trig_cnt  <= 4'd0;
         trig      <= 1'b0;
      end else begin
         state     <= state_nx;
         tick_cnt  <= tick_nx;
         step      <= step_nx;
         step_tick <= enter;
         trig_cnt  <= trig_nx;
         trig      <= trig_nx != 4'd0;
      end
   end
   // pattern edits; a clear drops any press in the same cycle
   always_ff @(posedge clk) begin
      if (rst || bus.clear) pattern <= 16'h0000;
      else if (bus.press_valid) pattern <= pattern ^ (16'h0001 << bus.press_index);
   end
   assign bus.pattern   = pattern;
   assign bus.step      = step;
   assign bus.step_tick = step_tick;
   assign bus.trig      = trig;
endmodule

// File: tb/tb_step_pattern_sequencer.sv
// tb_step_pattern_sequencer: directed and randomized checks of the step sequencer against an edge-counting reference model
module tb_step_pattern_sequencer;
   localparam int TW = 24;
   localparam int TL = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   step_pattern_sequencer_if #(.TEMPO_W(TW)) bus();
   step_pattern_sequencer #(.TEMPO_W(TW), .TRIG_LEN(TL)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   logic [15:0] m_pat;
   bit          m_run, m_tick;
   int          m_step, k, entry_edge, last_arm;

   task automatic tick();
      int eff;
      bit ent;
      eff = (bus.period < 2) ? 2 : int'(bus.period);
      ent = 0;
      k++;
      if (rst) begin
         m_pat = 0; m_run = 0; m_step = 0; m_tick = 0; last_arm = -1000;
      end else begin
         if (!m_run && bus.run) begin
            m_run = 1; ent = 1;
         end else if (m_run && !bus.run) begin
            m_run = 0;
         end else if (m_run && (k - entry_edge) >= eff) begin
`ifdef SEQ_LOOP_LEN_EN
            m_step = (m_step >= int'(bus.loop_len)) ? 0 : m_step + 1;
`else
            m_step = (m_step + 1) % 16;
`endif
            ent = 1;
         end
         if (ent) begin
            entry_edge = k;
            if (m_pat[m_step]) last_arm = k;
         end
         if (bus.clear) m_pat = 0;
         else if (bus.press_valid) m_pat[bus.press_index] = ~m_pat[bus.press_index];
         m_tick = ent;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic bit exp_trig();
      return (k - last_arm) < TL;
   endfunction

   task automatic press(input int idx);
      bus.press_valid = 1; bus.press_index = 4'(idx);
      tick();
      bus.press_valid = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      tick(); tick();
      total += 4;
      if (bus.pattern !== 16'h0000) begin bad++; $display("FAIL reset_pattern got=%h exp=0000", bus.pattern); end
      if (bus.step !== 4'd0) begin bad++; $display("FAIL reset_step got=%0d exp=0", bus.step); end
      if (bus.step_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", bus.step_tick); end
      if (bus.trig !== 1'b0) begin bad++; $display("FAIL reset_trig got=%b exp=0", bus.trig); end
      rst = 0;
      tick();
   endtask

   task automatic test_toggle();
      press(3);
      total++;
      if (bus.pattern !== 16'h0008) begin bad++; $display("FAIL toggle_set got=%h exp=0008", bus.pattern); end
      press(3);
      total++;
      if (bus.pattern !== 16'h0000) begin bad++; $display("FAIL toggle_clr got=%h exp=0000", bus.pattern); end
   endtask

   task automatic test_run_wrap();
      press(0);
      bus.period = 4; bus.run = 1;
      for (int c = 1; c <= 70; c++) begin
         tick();
         total += 3;
         if (bus.step !== 4'(m_step)) begin bad++; $display("FAIL run_step c=%0d got=%0d exp=%0d", c, bus.step, m_step); end
         if (bus.step_tick !== m_tick) begin bad++; $display("FAIL run_tick c=%0d got=%b exp=%b", c, bus.step_tick, m_tick); end
         if (bus.trig !== exp_trig()) begin bad++; $display("FAIL run_trig c=%0d got=%b exp=%b", c, bus.trig, exp_trig()); end
         if (c == 65) begin
            total++;
            if ({bus.step_tick, bus.step, bus.trig} !== 6'b1_0000_1) begin
               bad++; $display("FAIL wrap_65 got tick=%b step=%0d trig=%b exp tick=1 step=0 trig=1", bus.step_tick, bus.step, bus.trig);
            end
         end
      end
      bus.run = 0;
      tick();
   endtask

   task automatic test_clear_collision();
      for (int i = 1; i < 16; i++) press(i);
      total++;
      if (bus.pattern !== 16'hFFFF) begin bad++; $display("FAIL fill got=%h exp=ffff", bus.pattern); end
      bus.clear = 1; bus.press_valid = 1; bus.press_index = 5;
      tick();
      bus.clear = 0; bus.press_valid = 0;
      total++;
      if (bus.pattern !== 16'h0000) begin bad++; $display("FAIL clear_wins got=%h exp=0000", bus.pattern); end
   endtask

   task automatic test_period_clamp();
      int n;
      for (int p = 0; p < 2; p++) begin
         bus.run = 0; tick(); tick();
         bus.period = TW'(p); bus.run = 1;
         n = 0;
         for (int c = 0; c < 8; c++) begin
            tick();
            n += int'(bus.step_tick);
            total++;
            if (bus.step_tick !== m_tick) begin bad++; $display("FAIL clamp_tick p=%0d c=%0d got=%b exp=%b", p, c, bus.step_tick, m_tick); end
         end
         total++;
         if (n != 4) begin bad++; $display("FAIL clamp_count p=%0d got=%0d exp=4", p, n); end
      end
      bus.run = 0; tick();
      bus.period = 6; bus.run = 1;
      for (int c = 0; c < 5; c++) tick();
      bus.period = 2;
      tick();
      total += 2;
      if (bus.step_tick !== 1'b1) begin bad++; $display("FAIL period_shrink got=%b exp=1", bus.step_tick); end
      if (bus.step !== 4'(m_step)) begin bad++; $display("FAIL period_shrink_step got=%0d exp=%0d", bus.step, m_step); end
      bus.run = 0; tick();
   endtask

   task automatic test_stop_restart();
      int guard;
      press(6);
      bus.period = 2; bus.run = 1;
      guard = 0;
      do begin tick(); guard++; end while (!(bus.step_tick === 1'b1 && bus.step === 4'd6) && guard < 200);
      total++;
      if (guard >= 200) begin bad++; $display("FAIL reach_step6 got=%0d exp=6", bus.step); end
      bus.run = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         total += 3;
         if (bus.step !== 4'd6) begin bad++; $display("FAIL hold_step got=%0d exp=6", bus.step); end
         if (bus.step_tick !== 1'b0) begin bad++; $display("FAIL hold_tick got=%b exp=0", bus.step_tick); end
         if (bus.trig !== exp_trig()) begin bad++; $display("FAIL hold_trig got=%b exp=%b", bus.trig, exp_trig()); end
      end
      bus.run = 1;
      tick();
      total += 3;
      if (bus.step_tick !== 1'b1) begin bad++; $display("FAIL restart_tick got=%b exp=1", bus.step_tick); end
      if (bus.step !== 4'd6) begin bad++; $display("FAIL restart_step got=%0d exp=6", bus.step); end
      if (bus.trig !== 1'b1) begin bad++; $display("FAIL restart_trig got=%b exp=1", bus.trig); end
      tick();
      rst = 1;
      tick();
      rst = 0;
      total += 3;
      if (bus.step !== 4'd0) begin bad++; $display("FAIL rst_step got=%0d exp=0", bus.step); end
      if (bus.pattern !== 16'h0000) begin bad++; $display("FAIL rst_pattern got=%h exp=0000", bus.pattern); end
      if (bus.trig !== 1'b0) begin bad++; $display("FAIL rst_trig got=%b exp=0", bus.trig); end
      tick();
      total += 2;
      if (bus.step_tick !== 1'b1) begin bad++; $display("FAIL rst_restart_tick got=%b exp=1", bus.step_tick); end
      if (bus.step !== 4'd0) begin bad++; $display("FAIL rst_restart_step got=%0d exp=0", bus.step); end
      bus.run = 0; tick();
   endtask

`ifdef SEQ_LOOP_LEN_EN
   task automatic test_loop_len();
      int seq[6] = '{0, 1, 2, 3, 0, 1};
      int n, guard;
      bus.loop_len = 3; bus.period = 2; bus.run = 1;
      n = 0; guard = 0;
      while (n < 6 && guard < 100) begin
         tick(); guard++;
         if (bus.step_tick === 1'b1) begin
            total++;
            if (bus.step !== 4'(seq[n])) begin bad++; $display("FAIL loop_seq n=%0d got=%0d exp=%0d", n, bus.step, seq[n]); end
            n++;
         end
      end
      guard = 0;
      while (!(bus.step_tick === 1'b1 && bus.step === 4'd3) && guard < 100) begin tick(); guard++; end
      bus.loop_len = 1;
      guard = 0;
      do begin tick(); guard++; end while (bus.step_tick !== 1'b1 && guard < 100);
      total++;
      if (bus.step !== 4'd0 || guard >= 100) begin bad++; $display("FAIL loop_shrink got=%0d exp=0", bus.step); end
      bus.run = 0; bus.loop_len = 15; tick();
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         bus.press_valid = ($urandom_range(0, 5) == 0);
         bus.press_index = 4'($urandom_range(0, 15));
         bus.clear = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 19) == 0) bus.run = ~bus.run;
         if ($urandom_range(0, 29) == 0) bus.period = TW'($urandom_range(0, 5));
`ifdef SEQ_LOOP_LEN_EN
         if ($urandom_range(0, 39) == 0) bus.loop_len = 4'($urandom_range(0, 15));
`endif
         rst = ($urandom_range(0, 299) == 0);
         tick();
         total += 4;
         if (bus.pattern !== m_pat) begin bad++; $display("FAIL rnd_pattern c=%0d got=%h exp=%h", c, bus.pattern, m_pat); end
         if (bus.step !== 4'(m_step)) begin bad++; $display("FAIL rnd_step c=%0d got=%0d exp=%0d", c, bus.step, m_step); end
         if (bus.step_tick !== m_tick) begin bad++; $display("FAIL rnd_tick c=%0d got=%b exp=%b", c, bus.step_tick, m_tick); end
         if (bus.trig !== exp_trig()) begin bad++; $display("FAIL rnd_trig c=%0d got=%b exp=%b", c, bus.trig, exp_trig()); end
      end
      rst = 0; bus.press_valid = 0; bus.clear = 0; bus.run = 0;
      tick();
   endtask

   initial begin
      k = 0; entry_edge = 0; last_arm = -1000; m_pat = 0; m_run = 0; m_step = 0; m_tick = 0;
      bus.press_valid = 0; bus.press_index = 0; bus.clear = 0; bus.run = 0; bus.period = 4;
`ifdef SEQ_LOOP_LEN_EN
      bus.loop_len = 15;
`endif
      #1;
      test_reset();
      test_toggle();
      test_run_wrap();
      test_clear_collision();
      test_period_clamp();
      test_stop_restart();
`ifdef SEQ_LOOP_LEN_EN
      test_loop_len();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
